// File: rtl/vedacao_multicanal_pkg.sv
`default_nettype none
// ============================================================================
// vedacao_pkg : shared head-state encoding and default press duration
// Rev 1.0 - initial multi-head release
// ============================================================================
package vedacao_pkg;

  typedef enum logic [1:0] {
    LIVRE  = 2'd0,
    ESPERA = 2'd1,
    PRENSA = 2'd2,
    VEDADA = 2'd3
  } estado_t;

  localparam int C_T_PRENSA_PADRAO = 3;

endpackage
`default_nettype wire

// File: rtl/vedacao_multicanal_if.sv
`default_nettype none
// ============================================================================
// vedacao_multicanal_if : sensor/magazine inputs and status outputs bundle
// Rev 1.0 - initial multi-head release
// ============================================================================
interface vedacao_multicanal_if #(
  parameter int N_CANAIS = 4,
  parameter int ROLHA_W  = 8
);

  logic [N_CANAIS-1:0] GARRAFA_PRESENTE;
  logic                CARREGA_ROLHAS;
  logic [ROLHA_W-1:0]  VALOR_ROLHAS;
  logic [N_CANAIS-1:0] GARRAFA_VEDADA;
  logic [N_CANAIS-1:0] PRENSA_ATIVA;
  logic [ROLHA_W-1:0]  ROLHAS_RESTANTES;
  logic                SEM_ROLHA;
  logic                ALARME_ESPERA;
  logic [N_CANAIS-1:0] ERRO_REMOCAO;

  modport master (
    output GARRAFA_PRESENTE, CARREGA_ROLHAS, VALOR_ROLHAS,
    input  GARRAFA_VEDADA, PRENSA_ATIVA, ROLHAS_RESTANTES,
           SEM_ROLHA, ALARME_ESPERA, ERRO_REMOCAO
  );

  modport slave (
    input  GARRAFA_PRESENTE, CARREGA_ROLHAS, VALOR_ROLHAS,
    output GARRAFA_VEDADA, PRENSA_ATIVA, ROLHAS_RESTANTES,
           SEM_ROLHA, ALARME_ESPERA, ERRO_REMOCAO
  );

endinterface
`default_nettype wire

// File: rtl/vedacao_multicanal_canal_vedacao.sv
`default_nettype none
// ============================================================================
// canal_vedacao : one sealing head - state machine plus press timer
// Rev 1.0 - initial multi-head release
// ============================================================================
module canal_vedacao
  import vedacao_pkg::*;
#(
  parameter int T_PRENSA = C_T_PRENSA_PADRAO
) (
  input  wire logic CLOCK,
  input  wire logic RESET,
  input  wire logic i_presence,
  input  wire logic i_gnt,
  output logic      o_req,
  output logic      o_espera,
  output logic      o_prensa,
  output logic      o_vedada,
  output logic      o_erro_remocao
);

  localparam int               CNT_W   = (T_PRENSA > 1) ? $clog2(T_PRENSA) : 1;
  localparam logic [CNT_W-1:0] C_CARGA = CNT_W'(T_PRENSA - 1);

  estado_t          r_estado, w_estado_prox;
  logic [CNT_W-1:0] r_cnt, w_cnt_prox;
  logic             r_erro, w_erro_prox;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_estado <= LIVRE;
      r_cnt    <= '0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      r_erro   <= w_erro_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_erro_prox   = 1'b0;
    case (r_estado)
      LIVRE: begin
        if (i_presence) w_estado_prox = ESPERA;
      end
      ESPERA: begin
        if (!i_presence) begin
          w_estado_prox = LIVRE;
        end else if (i_gnt) begin
          w_estado_prox = PRENSA;
          w_cnt_prox    = C_CARGA;
        end
      end
      PRENSA: begin
        // A removed bottle aborts the press; the cork is already spent
        if (!i_presence) begin
          w_estado_prox = LIVRE;
          w_cnt_prox    = '0;
          w_erro_prox   = 1'b1;
        end else if (r_cnt == '0) begin
          w_estado_prox = VEDADA;
        end else begin
          w_cnt_prox = r_cnt - CNT_W'(1);
        end
      end
      VEDADA: begin
        if (!i_presence) w_estado_prox = LIVRE;
      end
      default: w_estado_prox = LIVRE;
    endcase
  end

  // Request masked by presence so a departing bottle never takes a cork
  assign o_req          = (r_estado == ESPERA) && i_presence;
  assign o_espera       = (r_estado == ESPERA);
  assign o_prensa       = (r_estado == PRENSA);
  assign o_vedada       = (r_estado == VEDADA);
  assign o_erro_remocao = r_erro;

endmodule
`default_nettype wire

// File: rtl/vedacao_multicanal.sv
`default_nettype none
// ============================================================================
// vedacao_multicanal : N sealing heads sharing one cork magazine (round-robin)
// Rev 1.0 - initial multi-head release
// ============================================================================
module vedacao_multicanal
  import vedacao_pkg::*;
#(
  parameter int N_CANAIS = 4,
  parameter int ROLHA_W  = 8,
  parameter int T_PRENSA = C_T_PRENSA_PADRAO
) (
  input  wire logic           CLOCK,
  input  wire logic           RESET,
  vedacao_multicanal_if.slave bus
);

  localparam int PTR_W = $clog2(N_CANAIS);

  logic [PTR_W-1:0]    r_ptr;
  logic [ROLHA_W-1:0]  r_rolhas;
  logic [N_CANAIS-1:0] w_req, w_gnt, w_espera, w_prensa, w_vedada, w_erro;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_gnt_valido;
  logic                w_sem_rolha;

  function automatic logic [PTR_W-1:0] f_rodar(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % N_CANAIS);
  endfunction

  // Scanning offsets high-to-low leaves the closest requester to the pointer
  always_comb begin
    w_gnt        = '0;
    w_gnt_idx    = '0;
    w_gnt_valido = 1'b0;
    if (!bus.CARREGA_ROLHAS && (r_rolhas != '0)) begin
      for (int off = N_CANAIS - 1; off >= 0; off--) begin
        if (w_req[f_rodar(r_ptr, off)]) begin
          w_gnt_idx    = f_rodar(r_ptr, off);
          w_gnt_valido = 1'b1;
        end
      end
    end
    if (w_gnt_valido) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_ptr    <= '0;
      r_rolhas <= '0;
    end else begin
      if (bus.CARREGA_ROLHAS) begin
        r_rolhas <= bus.VALOR_ROLHAS;
      end else if (w_gnt_valido) begin
        r_rolhas <= r_rolhas - ROLHA_W'(1);
      end
      if (w_gnt_valido) r_ptr <= f_rodar(w_gnt_idx, 1);
    end
  end

  for (genvar gi = 0; gi < N_CANAIS; gi++) begin : g_canal
    canal_vedacao #(
      .T_PRENSA (T_PRENSA)
    ) u_canal (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .i_presence     (bus.GARRAFA_PRESENTE[gi]),
      .i_gnt          (w_gnt[gi]),
      .o_req          (w_req[gi]),
      .o_espera       (w_espera[gi]),
      .o_prensa       (w_prensa[gi]),
      .o_vedada       (w_vedada[gi]),
      .o_erro_remocao (w_erro[gi])
    );
  end

  assign w_sem_rolha          = (r_rolhas == '0);
  assign bus.ROLHAS_RESTANTES = r_rolhas;
  assign bus.SEM_ROLHA        = w_sem_rolha;
  assign bus.ALARME_ESPERA    = (|w_espera) && w_sem_rolha;
  assign bus.GARRAFA_VEDADA   = w_vedada;
  assign bus.PRENSA_ATIVA     = w_prensa;
  assign bus.ERRO_REMOCAO     = w_erro;

endmodule
`default_nettype wire
